// File: rtl/ps2_kbd_event_ctrl.sv
// rtl/ps2_kbd_event_ctrl.sv - PS/2 scan byte decoder, held-key bitmap and key event FIFO
// Optional typematic repeat filtering for mapped keys: define KBD_REPEAT_FILTER_EN.
module ps2_kbd_event_ctrl #(
  parameter int FIFO_AW = 2,
  parameter int E1_SKIP = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       byte_vld,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_rel,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] keys_held,
  output logic       overflow
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = (E1_SKIP > 0) ? $clog2(E1_SKIP + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXTBRK,
    S_SKIP
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  state_t        w_restart;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_emit;
  logic          w_emit_ext;
  logic          w_emit_rel;
  logic          w_is_prefix;
  logic          w_is_noise;
  logic          w_is_fake;

  logic          r_pend_vld;
  logic [7:0]    r_pend_code;
  logic          r_pend_ext;
  logic          r_pend_rel;

  logic [9:0]       r_mem [DEPTH];
  logic [FIFO_AW:0] r_wr;
  logic [FIFO_AW:0] r_rd;
  logic [7:0]       r_keys;
  logic             r_ovf;
  logic [9:0]       w_head;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push_req;
  logic             w_push;
  logic [3:0]       w_key;
  logic             w_key_hit;
  logic [2:0]       w_key_idx;
  logic             w_repeat;

  // Returns {hit, bitmap index} for the eight game keys.
  function automatic logic [3:0] key_map(input logic [7:0] code, input logic ext);
    logic [3:0] m;
    m = 4'h0;
    case ({ext, code})
      9'h01D: m = 4'h8;
      9'h01C: m = 4'h9;
      9'h01B: m = 4'hA;
      9'h023: m = 4'hB;
      9'h175: m = 4'hC;
      9'h16B: m = 4'hD;
      9'h172: m = 4'hE;
      9'h174: m = 4'hF;
      default: m = 4'h0;
    endcase
    return m;
  endfunction

  always_comb begin
    w_is_prefix = (byte_in == 8'hE0) || (byte_in == 8'hE1) || (byte_in == 8'hF0);
    w_is_fake   = (byte_in == 8'h12) || (byte_in == 8'h59);
    w_is_noise  = (byte_in == 8'h00) || (byte_in == 8'hAA) || (byte_in == 8'hEE) ||
                  (byte_in == 8'hFA) || (byte_in == 8'hFE) || (byte_in == 8'hFF);
    case (byte_in)
      8'hE0:   w_restart = S_EXT;
      8'hF0:   w_restart = S_BRK;
      8'hE1:   w_restart = S_SKIP;
      default: w_restart = S_IDLE;
    endcase
  end

  // A misplaced prefix is treated as the start of a fresh sequence.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_emit      = 1'b0;
    w_emit_ext  = 1'b0;
    w_emit_rel  = 1'b0;
    if (byte_vld) begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = w_restart;
          w_emit      = !w_is_prefix && !w_is_noise;
        end
        S_EXT: begin
          if (byte_in == 8'hF0) begin
            w_state_nxt = S_EXTBRK;
          end else if (w_is_fake) begin
            w_state_nxt = S_IDLE;
          end else if (w_is_prefix) begin
            w_state_nxt = w_restart;
          end else begin
            w_state_nxt = S_IDLE;
            w_emit      = 1'b1;
            w_emit_ext  = 1'b1;
          end
        end
        S_BRK: begin
          w_state_nxt = w_is_prefix ? w_restart : S_IDLE;
          w_emit      = !w_is_prefix;
          w_emit_rel  = 1'b1;
        end
        S_EXTBRK: begin
          if (w_is_fake) begin
            w_state_nxt = S_IDLE;
          end else if (w_is_prefix) begin
            w_state_nxt = w_restart;
          end else begin
            w_state_nxt = S_IDLE;
            w_emit      = 1'b1;
            w_emit_ext  = 1'b1;
            w_emit_rel  = 1'b1;
          end
        end
        S_SKIP: begin
          w_cnt_nxt = (r_cnt == '0) ? '0 : r_cnt - CW'(1);
          if (r_cnt <= CW'(1)) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
      if (r_state != S_SKIP && byte_in == 8'hE1) begin
        w_cnt_nxt = CW'(E1_SKIP);
      end
    end
  end

  always_comb begin
    w_key     = key_map(r_pend_code, r_pend_ext);
    w_key_hit = w_key[3];
    w_key_idx = w_key[2:0];
    w_repeat  = w_key_hit && !r_pend_rel && r_keys[w_key_idx];
`ifdef KBD_REPEAT_FILTER_EN
    w_push_req = r_pend_vld && !w_repeat;
`else
    w_push_req = r_pend_vld;
`endif
    w_empty   = (r_wr == r_rd);
    w_full    = (r_wr[FIFO_AW] != r_rd[FIFO_AW]) &&
                (r_wr[FIFO_AW-1:0] == r_rd[FIFO_AW-1:0]);
    w_pop     = !w_empty && evt_ready;
    w_push    = w_push_req && (!w_full || w_pop);
    w_head    = r_mem[r_rd[FIFO_AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_pend_vld  <= 1'b0;
      r_pend_code <= 8'h00;
      r_pend_ext  <= 1'b0;
      r_pend_rel  <= 1'b0;
      r_wr        <= '0;
      r_rd        <= '0;
      r_keys      <= 8'h00;
      r_ovf       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_pend_vld  <= w_emit;
      r_pend_code <= byte_in;
      r_pend_ext  <= w_emit_ext;
      r_pend_rel  <= w_emit_rel;
      if (w_push) begin
        r_wr <= r_wr + {{FIFO_AW{1'b0}}, 1'b1};
      end
      if (w_pop) begin
        r_rd <= r_rd + {{FIFO_AW{1'b0}}, 1'b1};
      end
      // Bitmap tracks the keyboard, not the queue, so dropped events still count.
      if (r_pend_vld && w_key_hit) begin
        r_keys[w_key_idx] <= !r_pend_rel;
      end
      if (w_push_req && !w_push) begin
        r_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr[FIFO_AW-1:0]] <= {r_pend_code, r_pend_ext, r_pend_rel};
    end
  end

  assign evt_valid = !w_empty;
  assign evt_code  = w_empty ? 8'h00 : w_head[9:2];
  assign evt_ext   = !w_empty && w_head[1];
  assign evt_rel   = !w_empty && w_head[0];
  assign keys_held = r_keys;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_ps2_kbd_event_ctrl.sv
// tb/tb_ps2_kbd_event_ctrl.sv - scoreboard bench for ps2_kbd_event_ctrl
module tb_ps2_kbd_event_ctrl;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       byte_vld = 1'b0;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_rel;
  logic       evt_valid;
  logic [7:0] keys_held;
  logic       overflow;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
  } evt_t;

  evt_t       exp_q[$];
  evt_t       got;
  evt_t       want;
  int         total = 0;
  int         bad = 0;
  int         n_pop = 0;
  int         rdy_mode = 0;
  logic       m_ext = 1'b0;
  logic       m_brk = 1'b0;
  int         m_skip = 0;
  logic [7:0] m_keys = 8'h00;
  logic       m_ovf = 1'b0;
  bit         filter_on;

  ps2_kbd_event_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .byte_in   (byte_in),
    .byte_vld  (byte_vld),
    .evt_code  (evt_code),
    .evt_ext   (evt_ext),
    .evt_rel   (evt_rel),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .keys_held (keys_held),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    evt_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      evt_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted head must match the next predicted event.
  always @(negedge clk) begin
    if (rst && evt_valid && evt_ready) begin
      total++;
      got = {evt_code, evt_ext, evt_rel};
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event: got code=%0h ext=%0b rel=%0b expected none",
                 evt_code, evt_ext, evt_rel);
      end else begin
        want = exp_q.pop_front();
        n_pop++;
        if (got !== want) begin
          bad++;
          $display("FAIL event: got code=%0h ext=%0b rel=%0b expected code=%0h ext=%0b rel=%0b",
                   got.code, got.ext, got.rel, want.code, want.ext, want.rel);
        end
      end
    end
  end

  function automatic int key_idx(input logic [7:0] c, input logic e);
    int k;
    k = -1;
    if (!e) begin
      case (c)
        8'h1D: k = 0;
        8'h1C: k = 1;
        8'h1B: k = 2;
        8'h23: k = 3;
        default: k = -1;
      endcase
    end else begin
      case (c)
        8'h75: k = 4;
        8'h6B: k = 5;
        8'h72: k = 6;
        8'h74: k = 7;
        default: k = -1;
      endcase
    end
    return k;
  endfunction

  task automatic model_evt(input logic [7:0] c, input logic e, input logic r);
    int  k;
    bit  queue_it;
    k = key_idx(c, e);
    queue_it = 1'b1;
    if (filter_on && !r && k >= 0 && m_keys[k]) queue_it = 1'b0;
    if (k >= 0) m_keys[k] = !r;
    if (queue_it) begin
      if (exp_q.size() < DEPTH) exp_q.push_back({c, e, r});
      else m_ovf = 1'b1;
    end
  endtask

  // Prefixes are flags on the next code; E1 swallows a fixed-length tail.
  task automatic model_byte(input logic [7:0] b);
    if (m_skip > 0) begin
      m_skip--;
    end else if (b == 8'hE1) begin
      m_skip = 7;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
      m_brk = 1'b0;
    end else if (b == 8'hF0) begin
      m_ext = m_ext && !m_brk;
      m_brk = 1'b1;
    end else begin
      if (m_ext && (b == 8'h12 || b == 8'h59)) begin
      end else if (!m_ext && !m_brk &&
                   (b == 8'h00 || b == 8'hAA || b == 8'hEE || b == 8'hFA ||
                    b == 8'hFE || b == 8'hFF)) begin
      end else begin
        model_evt(b, m_ext, m_brk);
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #1;
    byte_in  = b;
    byte_vld = 1'b1;
    model_byte(b);
    @(posedge clk);
    #1;
    byte_vld = 1'b0;
    byte_in  = 8'($urandom);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    m_skip = 0;
    m_keys = 8'h00;
    m_ovf  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      chk({name, "_drain_timeout"}, exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({name, "_empty"}, evt_valid, 0);
  endtask

  initial begin
    int p0;
    int g;
    int r;
    logic [7:0] b;
    logic [7:0] mapped[8];
    mapped = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h75, 8'h6B, 8'h72, 8'h74};
`ifdef KBD_REPEAT_FILTER_EN
    filter_on = 1'b1;
`else
    filter_on = 1'b0;
`endif

    rdy_mode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", evt_valid, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_keys", keys_held, 0);
    chk("reset_head", {evt_code, evt_ext, evt_rel}, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    send(8'h1D);
    @(negedge clk);
    chk("lat_not_yet", evt_valid, 0);
    @(negedge clk);
    chk("lat_valid", evt_valid, 1);
    chk("lat_code", evt_code, 8'h1D);
    chk("lat_flags", {evt_ext, evt_rel}, 0);
    chk("lat_keys", keys_held, 8'h01);
    @(negedge clk);
    chk("hold_code", evt_code, 8'h1D);
    rdy_mode = 1;
    wait_drain("t1");

    send(8'hE0); send(8'h75);
    wait_drain("up_press");
    chk("up_held", keys_held[4], 1);
    send(8'hE0); send(8'hF0); send(8'h75);
    wait_drain("up_rel");
    chk("up_released", keys_held[4], 0);

    p0 = n_pop;
    send(8'h1C); send(8'h1C); send(8'h1C);
    wait_drain("repeat");
    chk("repeat_count", n_pop - p0, filter_on ? 1 : 3);
    chk("repeat_key", keys_held[1], 1);

    do_reset();
    rdy_mode = 0;
    send(8'h1D); send(8'h1C); send(8'h1B); send(8'h23); send(8'hE0); send(8'h75);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("ovf_set", overflow, 1);
    chk("ovf_keys", keys_held, 8'h1F);
    chk("ovf_model", m_ovf, 1);
    p0 = n_pop;
    rdy_mode = 1;
    wait_drain("ovf");
    chk("ovf_drained", n_pop - p0, 4);
    chk("ovf_sticky", overflow, 1);

    do_reset();
    p0 = n_pop;
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    send(8'h23);
    wait_drain("pause");
    chk("pause_count", n_pop - p0, 1);
    chk("pause_keys", keys_held, 8'h08);

    send(8'hE0);
    do_reset();
    p0 = n_pop;
    send(8'h75);
    wait_drain("rst_mid");
    chk("rst_mid_count", n_pop - p0, 1);
    chk("rst_mid_keys", keys_held, 8'h00);

    do_reset();
    rdy_mode = 2;
    for (int i = 0; i < 400; i++) begin
      g = 0;
      while (exp_q.size() >= DEPTH - 1 && g < 100) begin
        @(posedge clk);
        g++;
      end
      r = $urandom_range(0, 15);
      case (r)
        0:       b = 8'hE0;
        1, 2:    b = 8'hF0;
        3:       b = ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'h1D;
        4:       b = ($urandom_range(0, 1) == 0) ? 8'h12 : 8'h59;
        5:       b = 8'hAA;
        6, 7, 8, 9, 10, 11: b = mapped[$urandom_range(0, 7)];
        default: b = 8'($urandom);
      endcase
      send(b);
    end
    rdy_mode = 1;
    wait_drain("random");
    chk("random_keys", keys_held, m_keys);
    chk("random_overflow", overflow, m_ovf);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
